// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with a single-cycle done/result handshake.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic                is_div, signed_a, signed_b, a_neg, b_neg;
    logic                div_zero, div_ovf, take;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, prod_fix;
    logic [XLEN+1:0]     rem_sh, rem_diff;
    logic [XLEN-1:0]     quo_fix, rem_fix, finish_val;

    // Operand classification: which operands are signed for this funct3
    always_comb begin
        is_div   = funct3_q[2];
        signed_a = is_div ? ~funct3_q[0] : (funct3_q[1:0] == 2'b01 || funct3_q[1:0] == 2'b10);
        signed_b = is_div ? ~funct3_q[0] : (funct3_q[1:0] == 2'b01);
        a_neg    = signed_a & a_q[XLEN-1];
        b_neg    = signed_b & b_q[XLEN-1];
        mag_a    = neg_word(a_q, a_neg);
        mag_b    = neg_word(b_q, b_neg);
        div_zero = is_div && (b_q == '0);
        div_ovf  = is_div && !funct3_q[0] && (a_q == MIN_NEG) && (b_q == '1);
    end

    // One iteration of each datapath; acc low half doubles as multiplier / quotient
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {rem_q, acc_q[XLEN-1]};
        rem_diff = rem_sh - {2'b00, b_q};
        take     = ~rem_diff[XLEN+1];
    end

    always_comb begin
        prod_fix = neg_dword(acc_q, neg_q);
        quo_fix  = neg_word(acc_q[XLEN-1:0], neg_q);
        rem_fix  = neg_word(rem_q[XLEN-1:0], neg_rem_q);
        case (funct3_q)
            3'b000:                 finish_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: finish_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         finish_val = quo_fix;
            default:                finish_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d  = S_PREP;
                    funct3_d = funct3;
                    a_d      = op_a;
                    b_d      = op_b;
                end
            end
            S_PREP: begin
                acc_d     = {{XLEN{1'b0}}, mag_a};
                b_d       = mag_b;
                rem_d     = '0;
                neg_d     = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                cnt_d     = CW'(XLEN - 1);
                state_d   = S_CALC;
                // Special cases preload the final quotient/remainder and skip CALC
                if (div_zero) begin
                    acc_d     = {{XLEN{1'b0}}, {XLEN{1'b1}}};
                    rem_d     = {1'b0, a_q};
                    neg_d     = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = S_FINISH;
                end else if (div_ovf) begin
                    acc_d     = {{XLEN{1'b0}}, MIN_NEG};
                    neg_d     = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = S_FINISH;
                end
            end
            S_CALC: begin
                if (is_div) begin
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], take};
                    rem_d = take ? rem_diff[XLEN:0] : rem_sh[XLEN:0];
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                result_d = finish_val;
                state_d  = S_IDLE;
            end
        endcase
        if (flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_FINISH);
    assign stall  = ((state_q == S_IDLE) && start) || (busy && !done);
    assign result = done ? finish_val : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed plan vectors, randomized
// operations against an arithmetic reference, back-to-back, flush and reset abort.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk = 1'b0;
    logic            reset_n, start, flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic            busy, stall, done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] last_exp;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M result rules
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, w;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        w  = '0;
        r  = '0;
        case (f)
            3'd0: begin w = ua * ub; r = w[31:0]; end
            3'd1: begin w = sa * sb; r = w[63:32]; end
            3'd2: begin w = sa * longint'(ub); r = w[63:32]; end
            3'd3: begin w = ua * ub; r = w[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else begin w = sa / sb; r = w[31:0]; end
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else begin w = sa % sb; r = w[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return LAT;
    endfunction

    // Issue one op from IDLE; reports done cycle (relative to start cycle 0) and result.
    // Returns positioned one cycle after done, just past the clock edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic stall_ok);
        lat = -1;
        res = '0;
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1;
        stall_ok = (stall === 1'b1);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                stall_ok = stall_ok && (stall === 1'b0);
                tick();
                break;
            end
            stall_ok = stall_ok && (stall === 1'b1) && (busy === 1'b1);
            tick();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({busy, stall, done, result} !== 35'h0)
            $display("FAIL reset_idle: got busy=%b stall=%b done=%b result=%h, expected all zero",
                     busy, stall, done, result);
        else n_pass++;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    task automatic test_directed;
        vec_t v[12];
        int lat;
        logic [31:0] res;
        logic stall_ok;
        v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        v[1]  = '{3'd3, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 34};
        v[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 34};
        v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        v[6]  = '{3'd5, 32'd100,        32'd7,         32'h0000_000E, 34};
        v[7]  = '{3'd7, 32'd100,        32'd7,         32'h0000_0002, 34};
        v[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        v[9]  = '{3'd6, 32'd7,          32'd0,         32'h0000_0007, 2};
        v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2};
        for (int i = 0; i < 12; i++) begin
            issue(v[i].f, v[i].a, v[i].b, lat, res, stall_ok);
            last_exp = v[i].exp;
            n_checks++;
            if (res !== v[i].exp)
                $display("FAIL dir%0d_result: got %h expected %h", i, res, v[i].exp);
            else n_pass++;
            n_checks++;
            if (lat != v[i].lat)
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
            else n_pass++;
            n_checks++;
            if (!stall_ok)
                $display("FAIL dir%0d_stall: got stall profile wrong expected %0d", i, 1);
            else n_pass++;
            #1;
            n_checks++;
            if ({busy, done} !== 2'b00)
                $display("FAIL dir%0d_after_done: got busy=%b done=%b expected 0 0", i, busy, done);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] res, a, b, exp;
        logic [2:0] f;
        logic stall_ok;
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = model(f, a, b);
            issue(f, a, b, lat, res, stall_ok);
            last_exp = exp;
            n_checks++;
            if (res !== exp)
                $display("FAIL rand%0d_result f3=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp);
            else n_pass++;
            n_checks++;
            if (lat != model_lat(f, a, b))
                $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, model_lat(f, a, b));
            else n_pass++;
        end
    endtask

    // start held high through FINISH: ignored there, then accepted from IDLE next cycle
    task automatic test_back_to_back;
        logic [31:0] exp1, exp2;
        int d1, d2;
        d1 = -1; d2 = -1;
        exp1 = model(3'd0, 32'd1234, 32'd5678);
        exp2 = model(3'd4, 32'hFFFF_FF00, 32'd16);
        funct3 = 3'd0; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
        tick();
        for (int c = 1; c <= 100 && d2 < 0; c++) begin
            #1;
            if (c == d1 + 1 && d1 > 0) begin
                n_checks++;
                if ({busy, stall} !== 2'b01)
                    $display("FAIL b2b_gap: got busy=%b stall=%b expected busy=0 stall=1", busy, stall);
                else n_pass++;
            end
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = c;
                    n_checks++;
                    if (result !== exp1) $display("FAIL b2b_first: got %h expected %h", result, exp1);
                    else n_pass++;
                    n_checks++;
                    if (stall !== 1'b0) $display("FAIL b2b_finish_stall: got %b expected 0", stall);
                    else n_pass++;
                    funct3 = 3'd4; op_a = 32'hFFFF_FF00; op_b = 32'd16;
                end else begin
                    d2 = c;
                    n_checks++;
                    if (result !== exp2) $display("FAIL b2b_second: got %h expected %h", result, exp2);
                    else n_pass++;
                end
            end
            tick();
        end
        start = 1'b0;
        last_exp = exp2;
        n_checks++;
        if (d1 != LAT || d2 != 2 * LAT + 1)
            $display("FAIL b2b_timing: got done at %0d,%0d expected %0d,%0d", d1, d2, LAT, 2 * LAT + 1);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush;
        int seen;
        seen = 0;
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if ({busy, stall, done} !== 3'b000)
            $display("FAIL flush_abort: got busy=%b stall=%b done=%b expected 0 0 0", busy, stall, done);
        else n_pass++;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) $display("FAIL flush_no_done: got %0d done pulses expected 0", seen);
        else n_pass++;
        n_checks++;
        if (result !== last_exp) $display("FAIL flush_result_held: got %h expected %h", result, last_exp);
        else n_pass++;
    endtask

    task automatic test_flush_start_idle;
        funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL flush_start_idle: got busy=%b expected 0", busy);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid;
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({busy, stall, done, result} !== 35'h0)
            $display("FAIL reset_mid: got busy=%b stall=%b done=%b result=%h expected all zero",
                     busy, stall, done, result);
        else n_pass++;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        last_exp = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_flush_start_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
